// File: rtl/move_collector.sv
// move_collector: round-robin drain of eight column move FIFOs into one
// ready/valid move stream. Each 160-bit column word carries eight 19-bit
// move slots; slots flagged invalid (bit 18) are skipped without a beat.
// Optional build macro MOVE_COLLECTOR_COUNT_EN adds a saturating counter of
// accepted moves on move_count; without it move_count is tied to zero.
module move_collector (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    col_done,
  input  logic [7:0]    col_empty,
  input  logic [1279:0] col_data,
  output logic [7:0]    col_rden,
  output logic [18:0]   m_move,
  output logic [2:0]    m_col,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          all_done,
  output logic [7:0]    move_count
);

  typedef enum logic [2:0] {SCAN, READ, LATCH, EMIT, DONE} state_t;

  state_t       state_reg, state_next;
  logic [2:0]   rr_ptr_reg, rr_ptr_next;
  logic [2:0]   sel_reg, sel_next;
  logic [2:0]   slot_idx_reg, slot_idx_next;
  logic [159:0] word_reg, word_next;

  logic [159:0] col_words [8];
  logic [18:0]  slots [8];
  logic [63:0]  unused_tail;
  logic [18:0]  cur_slot;
  logic         slot_valid;
  logic         found;
  logic [2:0]   pick;

  // Split the flat column bus into per-column words and the held word into
  // slots. The top byte of every column word carries no move data.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_split
      assign col_words[gi]             = col_data[160*gi +: 160];
      assign unused_tail[8*gi +: 8]    = col_data[160*gi+152 +: 8];
      assign slots[gi]                 = word_reg[19*gi +: 19];
    end
  endgenerate

  assign cur_slot   = slots[slot_idx_reg];
  assign slot_valid = ~cur_slot[18];

  // Round-robin search: first nonempty column at or above rr_ptr, wrapping.
  // Walking offsets from high to low leaves the smallest offset as winner.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_reg;
    for (int i = 7; i >= 0; i--) begin
      if (!col_empty[rr_ptr_reg + 3'(i)]) begin
        found = 1'b1;
        pick  = rr_ptr_reg + 3'(i);
      end
    end
  end

  // State and datapath registers; reset drops any held word or pending move.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SCAN;
      rr_ptr_reg   <= 3'd0;
      sel_reg      <= 3'd0;
      slot_idx_reg <= 3'd0;
      word_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      sel_reg      <= sel_next;
      slot_idx_reg <= slot_idx_next;
      word_reg     <= word_next;
    end
  end

  // Next-state and output decode. Reads are only ever issued from READ, so a
  // column that fills while a word is being emitted waits for the next SCAN.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    sel_next      = sel_reg;
    slot_idx_next = slot_idx_reg;
    word_next     = word_reg;
    col_rden      = 8'h00;
    m_valid       = 1'b0;
    case (state_reg)
      SCAN: begin
        if (found) begin
          sel_next   = pick;
          state_next = READ;
        end else if (col_done == 8'hFF) begin
          state_next = DONE;
        end
      end
      READ: begin
        col_rden   = 8'h01 << sel_reg;
        state_next = LATCH;
      end
      LATCH: begin
        // FIFO data appears the cycle after the read strobe.
        word_next     = col_words[sel_reg];
        slot_idx_next = 3'd0;
        rr_ptr_next   = sel_reg + 3'd1;
        state_next    = EMIT;
      end
      EMIT: begin
        m_valid = slot_valid;
        // Invalid slots advance unconditionally; valid ones wait for ready.
        if (!slot_valid || m_ready) begin
          if (slot_idx_reg == 3'd7) begin
            state_next = SCAN;
          end else begin
            slot_idx_next = slot_idx_reg + 3'd1;
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // Outputs are zero whenever no move is offered.
  assign m_move   = m_valid ? cur_slot : 19'd0;
  assign m_col    = m_valid ? sel_reg : 3'd0;
  assign all_done = (state_reg == DONE);

`ifdef MOVE_COLLECTOR_COUNT_EN
  logic [7:0] count_reg;

  // Saturating count of accepted moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 8'h00;
    end else if (m_valid && m_ready && count_reg != 8'hFF) begin
      count_reg <= count_reg + 8'h01;
    end
  end

  assign move_count = count_reg;
`else
  assign move_count = 8'h00;
`endif

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector with a small registered-output FIFO model
// per column and a handshake/read monitor.
module tb_move_collector;

  localparam logic [18:0] INV = 19'h40000;
`ifdef MOVE_COLLECTOR_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    col_done;
  logic [7:0]    col_empty;
  logic [1279:0] col_data = '0;
  logic [7:0]    col_rden;
  logic [18:0]   m_move;
  logic [2:0]    m_col;
  logic          m_valid;
  logic          m_ready;
  logic          all_done;
  logic [7:0]    move_count;

  int checks = 0;
  int failures = 0;

  move_collector dut (
    .clk(clk), .reset(reset), .col_done(col_done), .col_empty(col_empty),
    .col_data(col_data), .col_rden(col_rden), .m_move(m_move), .m_col(m_col),
    .m_valid(m_valid), .m_ready(m_ready), .all_done(all_done),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Column FIFO model: registered output, data valid the cycle after rden.
  logic [159:0] fifo_mem [8][8];
  int wr_cnt [8];
  int rd_cnt [8];

  always_comb begin
    for (int c = 0; c < 8; c++) col_empty[c] = (wr_cnt[c] == rd_cnt[c]);
  end

  always @(posedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (col_rden[c] && (rd_cnt[c] != wr_cnt[c])) begin
        col_data[c*160 +: 160] <= fifo_mem[c][rd_cnt[c] % 8];
        rd_cnt[c] <= rd_cnt[c] + 1;
      end
    end
  end

  // Monitor: log read strobes and accepted moves (not during reset).
  int rden_n = 0;
  int hs_n = 0;
  int multi_n = 0;
  int rden_log [1024];
  int hs_col_log [1024];
  logic [18:0] hs_move_log [1024];

  function automatic int low_bit(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      if (col_rden != 8'h00) begin
        rden_log[rden_n % 1024] <= low_bit(col_rden);
        rden_n <= rden_n + 1;
        if ($countones(col_rden) != 1) multi_n <= multi_n + 1;
      end
      if (m_valid && m_ready) begin
        hs_col_log[hs_n % 1024]  <= int'(m_col);
        hs_move_log[hs_n % 1024] <= m_move;
        hs_n <= hs_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [159:0] w);
    fifo_mem[c][wr_cnt[c] % 8] = w;
    wr_cnt[c] = wr_cnt[c] + 1;
  endtask

  task automatic wait_rden(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_rden != 8'h00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return (CNT_EN != 0) ? ((n > 255) ? 32'd255 : 32'(n)) : 32'd0;
  endfunction

  logic [159:0] word_a, word_c0, word_c0b, word_c5, word_d, word_e;
  bit ok;
  int hbase, rbase;
  bit mid_checked;

  initial begin
    for (int c = 0; c < 8; c++) begin
      wr_cnt[c] = 0;
      rd_cnt[c] = 0;
    end
    word_a   = {8'hA5, {7{INV}}, 19'h00C1C};
    word_c0  = {8'h00, {7{INV}}, 19'h00041};
    word_c0b = {8'h00, {7{INV}}, 19'h00082};
    word_c5  = {8'hFF, 19'h00145, {7{INV}}};
    word_d   = {8'h00, {5{INV}}, 19'h00303, 19'h00202, 19'h00101};
    reset = 1'b1;
    col_done = 8'h00;
    m_ready = 1'b1;

    // Reset state, with ready high to show it has no effect under reset.
    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_move", m_move, 0);
    check("rst_col", m_col, 0);
    check("rst_rden", col_rden, 0);
    check("rst_done", all_done, 0);
    check("rst_count", move_count, 0);

    // Single valid slot in column 3, consumer always ready.
    reset = 1'b0;
    hbase = hs_n;
    rbase = rden_n;
    push(3, word_a);
    wait_rden(ok);
    check("a_rden_seen", ok, 1);
    check("a_rden", col_rden, 8'h08);
    @(negedge clk);
    check("a_rden_once", col_rden, 8'h00);
    check("a_valid_early", m_valid, 0);
    @(negedge clk);
    check("a_valid", m_valid, 1);
    check("a_move", m_move, 19'h00C1C);
    check("a_col", m_col, 3);
    repeat (12) @(negedge clk);
    check("a_hs", hs_n - hbase, 1);
    check("a_reads", rden_n - rbase, 1);
    check("a_idle", m_valid, 0);
    check("a_count", move_count, cnt_exp(1));

    // Same word with back-pressure: held 5 cycles, accepted on the 6th.
    m_ready = 1'b0;
    hbase = hs_n;
    push(3, word_a);
    wait_rden(ok);
    check("b_rden_seen", ok, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("b_hold_valid", m_valid, 1);
      check("b_hold_move", m_move, 19'h00C1C);
      check("b_hold_col", m_col, 3);
      if (i == 5) m_ready = 1'b1;
      @(negedge clk);
    end
    check("b_released", m_valid, 0);
    check("b_hs", hs_n - hbase, 1);
    repeat (10) @(negedge clk);
    check("b_hs_final", hs_n - hbase, 1);
    check("b_count", move_count, cnt_exp(2));

    // Round robin from pointer 0: col 0, col 5, then refilled col 0 after 5.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    hbase = hs_n;
    rbase = rden_n;
    push(0, word_c0);
    push(5, word_c5);
    wait_rden(ok);
    check("c_rden_seen", ok, 1);
    check("c_first", col_rden, 8'h01);
    push(0, word_c0b);
    repeat (45) @(negedge clk);
    check("c_reads", rden_n - rbase, 3);
    check("c_order0", rden_log[rbase], 0);
    check("c_order1", rden_log[rbase + 1], 5);
    check("c_order2", rden_log[rbase + 2], 0);
    check("c_hs", hs_n - hbase, 3);
    check("c_hs_col1", hs_col_log[hbase + 1], 5);
    check("c_hs_move1", hs_move_log[hbase + 1], 19'h00145);
    check("c_hs_move2", hs_move_log[hbase + 2], 19'h00082);
    check("c_count", move_count, cnt_exp(3));

    // Reset while slot 2 is offered: move dropped, word not replayed.
    m_ready = 1'b0;
    hbase = hs_n;
    rbase = rden_n;
    push(2, word_d);
    wait_rden(ok);
    check("d_rden_seen", ok, 1);
    repeat (2) @(negedge clk);
    check("d_slot0", m_move, 19'h00101);
    m_ready = 1'b1;
    @(negedge clk);
    check("d_slot1", m_move, 19'h00202);
    @(negedge clk);
    check("d_slot2", m_move, 19'h00303);
    check("d_slot2_valid", m_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("d_rst_valid", m_valid, 0);
    check("d_rst_count", move_count, 0);
    check("d_hs", hs_n - hbase, 2);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("d_no_replay_hs", hs_n - hbase, 2);
    check("d_no_replay_rd", rden_n - rbase, 1);
    check("d_idle", m_valid, 0);

    // 300 accepted moves: saturating count (or zero without the counter).
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    hbase = hs_n;
    for (int w = 0; w < 38; w++) begin
      for (int s = 0; s < 8; s++) begin
        word_e[19*s +: 19] = (w == 37 && s >= 4) ? INV : 19'(w * 8 + s);
      end
      word_e[159:152] = 8'h3C;
      push(w % 8, word_e);
    end
    mid_checked = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!mid_checked && (hs_n - hbase) == 100) begin
        mid_checked = 1'b1;
        check("e_count_100", move_count, cnt_exp(100));
      end
      if ((hs_n - hbase) >= 300 && !m_valid) break;
    end
    repeat (5) @(negedge clk);
    check("e_mid_seen", mid_checked, 1);
    check("e_hs", hs_n - hbase, 300);
    check("e_count_sat", move_count, cnt_exp(300));
    check("e_last_move", hs_move_log[(hs_n - 1) % 1024], 19'd299);

    // Everything empty and done: all_done within 2 cycles, sticky, no reads.
    reset = 1'b1;
    col_done = 8'hFF;
    @(negedge clk);
    reset = 1'b0;
    rbase = rden_n;
    repeat (2) @(negedge clk);
    check("f_all_done", all_done, 1);
    push(1, word_a);
    repeat (6) @(negedge clk);
    check("f_sticky", all_done, 1);
    check("f_no_reads", rden_n - rbase, 0);
    check("f_rden", col_rden, 0);
    check("f_valid", m_valid, 0);
    check("onehot_rden", multi_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
